cpu_io_buffer: RTL

CPU_IO_BUFFER -- requirements
Module: cpu_io_buffer

---
 rtl/cpu_io_buffer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/cpu_io_buffer.sv
// First-word-fall-through buffer between a CPU output port and a downstream consumer,
// sequenced by an IDLE/RUN/DRAIN/DONE controller.
module cpu_io_buffer #(
    parameter int WIDTH    = 36,
    parameter int DEPTH    = 16,
    parameter int PTRWIDTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                startIO,
    input  logic                outFlag,
    input  logic                endFlag,
    input  logic [WIDTH-1:0]    out,
    output logic [WIDTH-1:0]    dataOut,
    output logic                dataValid,
    input  logic                dataReady,
    output logic                full,
    output logic                empty,
    output logic [PTRWIDTH:0]   count,
    output logic                overflow,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [PTRWIDTH-1:0] PTR_ONE  = PTRWIDTH'(1);
    localparam logic [PTRWIDTH:0]   CNT_ONE  = (PTRWIDTH+1)'(1);
    localparam logic [PTRWIDTH:0]   CNT_FULL = (PTRWIDTH+1)'(DEPTH);

    state_t                state_q, state_d;
    logic [PTRWIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTRWIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTRWIDTH:0]     count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [WIDTH-1:0]      mem_q [DEPTH];

    logic push_req;
    logic push_ok;
    logic pop;
    logic drop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_FULL);
    assign dataValid = !empty;
    assign dataOut   = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign done      = (state_q == DONE);

    // A pop frees a slot in the same cycle, so a push onto a full buffer still lands.
    assign pop      = dataValid && dataReady && (state_q != IDLE);
    assign push_req = (state_q == RUN) && outFlag;
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && !push_ok;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (drop) overflow_d = 1'b1;

        case (state_q)
            IDLE: begin
                // Each new run starts from a clean buffer and a cleared overflow flag.
                if (startIO) begin
                    state_d    = RUN;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            RUN: begin
                if (endFlag || !startIO) state_d = DRAIN;
            end
            DRAIN: begin
                if (count_d == '0) state_d = DONE;
            end
            DONE: begin
                if (!startIO) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= out;
    end

endmodule
